// File: rtl/nested_loop_counter.sv
// nested_loop_counter: two-level (inner/outer) loop index generator with roll-over pulse and sticky done.
// Define NESTED_LOOP_ADV_DLY_EN to re-time adv through an ADV_DLY-deep delay line before it acts.
module nested_loop_counter #(
  parameter int INNER_W     = 6,
  parameter int OUTER_W     = 4,
  parameter int INNER_START = 1,
  parameter int INNER_LAST  = 49,
  parameter int OUTER_START = 0,
  parameter int OUTER_LAST  = 9,
  parameter int ADV_DLY     = 3
) (
  input  logic               clk,
  input  logic               loop_rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [INNER_W-1:0] inner_idx,
  output logic [OUTER_W-1:0] outer_idx,
  output logic               inner_last,
  output logic               wrap,
  output logic               done
);

  // Reject parameter sets whose ranges are empty or not representable in the index width.
  if (INNER_W < 1 || OUTER_W < 1) begin : g_bad_width
    $error("nested_loop_counter: index widths must be at least 1");
  end
  if (INNER_START < 0 || INNER_START > INNER_LAST) begin : g_bad_inner_range
    $error("nested_loop_counter: need 0 <= INNER_START <= INNER_LAST");
  end
  if (longint'(INNER_LAST) >= (longint'(1) << INNER_W)) begin : g_bad_inner_last
    $error("nested_loop_counter: INNER_LAST does not fit in INNER_W bits");
  end
  if (OUTER_START < 0 || OUTER_START > OUTER_LAST) begin : g_bad_outer_range
    $error("nested_loop_counter: need 0 <= OUTER_START <= OUTER_LAST");
  end
  if (longint'(OUTER_LAST) >= (longint'(1) << OUTER_W)) begin : g_bad_outer_last
    $error("nested_loop_counter: OUTER_LAST does not fit in OUTER_W bits");
  end
  if (ADV_DLY < 0) begin : g_bad_dly
    $error("nested_loop_counter: ADV_DLY must be non-negative");
  end

  localparam logic [INNER_W-1:0] IN_FIRST  = INNER_W'(INNER_START);
  localparam logic [INNER_W-1:0] IN_FINAL  = INNER_W'(INNER_LAST);
  localparam logic [OUTER_W-1:0] OUT_FIRST = OUTER_W'(OUTER_START);
  localparam logic [OUTER_W-1:0] OUT_FINAL = OUTER_W'(OUTER_LAST);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [INNER_W-1:0] inner_q, inner_d;
  logic [OUTER_W-1:0] outer_q, outer_d;
  logic               wrap_q, wrap_d;
  logic               adv_e;
  logic               at_inner_last;
  logic               at_outer_last;

`ifdef NESTED_LOOP_ADV_DLY_EN
  if (ADV_DLY == 0) begin : g_no_dly
    assign adv_e = adv;
  end else begin : g_dly
    logic [ADV_DLY-1:0] dly_q;

    // clr flushes in-flight strobes so a restart never sees stale advances.
    always_ff @(posedge clk or negedge loop_rst_n) begin
      if (!loop_rst_n) begin
        dly_q <= '0;
      end else if (clr) begin
        dly_q <= '0;
      end else begin
        dly_q[0] <= adv;
        for (int unsigned i = 1; i < ADV_DLY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign adv_e = dly_q[ADV_DLY-1];
  end
`else
  assign adv_e = adv;
`endif

  assign at_inner_last = (inner_q == IN_FINAL);
  assign at_outer_last = (outer_q == OUT_FINAL);

  always_ff @(posedge clk or negedge loop_rst_n) begin
    if (!loop_rst_n) begin
      state_q <= ST_RUN;
      inner_q <= IN_FIRST;
      outer_q <= OUT_FIRST;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inner_q <= inner_d;
      outer_q <= outer_d;
      wrap_q  <= wrap_d;
    end
  end

  // Final step only latches done: indices stay parked on their last values.
  always_comb begin
    state_d = state_q;
    inner_d = inner_q;
    outer_d = outer_q;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = ST_RUN;
      inner_d = IN_FIRST;
      outer_d = OUT_FIRST;
    end else if (adv_e) begin
      unique case (state_q)
        ST_RUN: begin
          if (!at_inner_last) begin
            inner_d = inner_q + 1'b1;
          end else if (!at_outer_last) begin
            inner_d = IN_FIRST;
            outer_d = outer_q + 1'b1;
            wrap_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign inner_idx  = inner_q;
  assign outer_idx  = outer_q;
  assign inner_last = at_inner_last;
  assign wrap       = wrap_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_nested_loop_counter.sv
// tb_nested_loop_counter: directed + randomized checks against a step-count reference model.
// Honors NESTED_LOOP_ADV_DLY_EN the same way as the design (delayed advance strobe).
module tb_nested_loop_counter;

  localparam int IW = 6;
  localparam int OW = 4;
  localparam int IS = 1;
  localparam int IL = 49;
  localparam int OS = 0;
  localparam int OL = 9;
  localparam int DLY = 3;
  localparam int NI = IL - IS + 1;
  localparam int NO = OL - OS + 1;
  localparam int N  = NI * NO;
`ifdef NESTED_LOOP_ADV_DLY_EN
  localparam int D = DLY;
`else
  localparam int D = 0;
`endif

  logic          clk;
  logic          loop_rst_n;
  logic          clr;
  logic          adv;
  logic [IW-1:0] inner_idx;
  logic [OW-1:0] outer_idx;
  logic          inner_last;
  logic          wrap;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: number of effective advances taken so far, plus pending delayed strobes.
  int m_s;
  bit m_wrap;
  bit pend[$];

  nested_loop_counter #(
    .INNER_W    (IW),
    .OUTER_W    (OW),
    .INNER_START(IS),
    .INNER_LAST (IL),
    .OUTER_START(OS),
    .OUTER_LAST (OL),
    .ADV_DLY    (DLY)
  ) dut (
    .clk       (clk),
    .loop_rst_n(loop_rst_n),
    .clr       (clr),
    .adv       (adv),
    .inner_idx (inner_idx),
    .outer_idx (outer_idx),
    .inner_last(inner_last),
    .wrap      (wrap),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_inner();
    return (m_s >= N) ? IL : IS + (m_s % NI);
  endfunction

  function automatic int m_outer();
    return (m_s >= N) ? OL : OS + (m_s / NI);
  endfunction

  function automatic int pend_sum();
    int s = 0;
    foreach (pend[i]) s += int'(pend[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_s    = 0;
    m_wrap = 1'b0;
    pend.delete();
    for (int i = 0; i < D; i++) pend.push_back(1'b0);
  endtask

  task automatic model_edge(input bit a, input bit c);
    bit ae;
    if (D == 0) begin
      ae = a;
    end else begin
      ae = pend.pop_front();
      pend.push_back(a);
    end
    m_wrap = 1'b0;
    if (c) begin
      model_reset();
    end else if (ae && m_s < N) begin
      m_s++;
      m_wrap = (m_s % NI == 0) && (m_s != N);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inner_idx",  32'(inner_idx),  32'(m_inner()));
    chk("outer_idx",  32'(outer_idx),  32'(m_outer()));
    chk("inner_last", 32'(inner_last), 32'(m_inner() == IL));
    chk("wrap",       32'(wrap),       32'(m_wrap));
    chk("done",       32'(done),       32'(m_s >= N));
  endtask

  task automatic step(input bit a, input bit c);
    adv = a;
    clr = c;
    @(posedge clk);
    model_edge(a, c);
    #1;
    check_all();
  endtask

  // Random advances until the model position reaches target (bounded), then check the DUT is there.
  task automatic advance_to(input int target);
    int guard = 0;
    while (m_s + pend_sum() < target && guard < 4 * target + 100) begin
      step($urandom_range(0, 3) != 0, 1'b0);
      guard++;
    end
    while (m_s < target && guard < 4 * target + 100) begin
      step(1'b0, 1'b0);
      guard++;
    end
    chk("reach_inner", 32'(inner_idx), 32'(IS + target % NI));
    chk("reach_outer", 32'(outer_idx), 32'(OS + target / NI));
  endtask

  initial begin
    loop_rst_n = 1'b0;
    clr = 1'b0;
    adv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    loop_rst_n = 1'b1;

    // Idle after reset.
    repeat (5) step(1'b0, 1'b0);
    chk("rst_inner", 32'(inner_idx), 32'(1));
    chk("rst_outer", 32'(outer_idx), 32'(0));
    chk("rst_last",  32'(inner_last), 32'(0));
    chk("rst_wrap",  32'(wrap), 32'(0));
    chk("rst_done",  32'(done), 32'(0));

    // First inner roll-over, then a couple of idle cycles to see wrap drop.
    repeat (NI) step(1'b1, 1'b0);
    repeat (D + 2) step(1'b0, 1'b0);
    chk("roll_inner", 32'(inner_idx), 32'(IS));
    chk("roll_outer", 32'(outer_idx), 32'(OS + 1));

    // Full traversal at full rate plus extra advances that must be ignored.
    step(1'b0, 1'b1);
    repeat (N + 10) step(1'b1, 1'b0);
    repeat (D + 2) step(1'b0, 1'b0);
    chk("full_done",  32'(done), 32'(1));
    chk("full_inner", 32'(inner_idx), 32'(IL));
    chk("full_outer", 32'(outer_idx), 32'(OL));
    chk("full_wrap",  32'(wrap), 32'(0));

    // Mid-traversal restart with a simultaneous advance.
    step(1'b0, 1'b1);
    advance_to(4 * NI + 19);
    step(1'b1, 1'b1);
    chk("clr_inner", 32'(inner_idx), 32'(IS));
    chk("clr_outer", 32'(outer_idx), 32'(OS));
    chk("clr_done",  32'(done), 32'(0));
    repeat (D + 2) step(1'b0, 1'b0);

    // Single strobe latency, then a strobe killed by clr one edge later.
    step(1'b1, 1'b0);
    repeat (D + 2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (D + 2) step(1'b0, 1'b0);

    // Random advance/clear mix.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
    end

    // Asynchronous reset dropped between edges.
    step(1'b0, 1'b1);
    advance_to(7 * NI + 5);
    adv = 1'b0;
    #3;
    loop_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_inner", 32'(inner_idx), 32'(1));
    chk("arst_outer", 32'(outer_idx), 32'(0));
    chk("arst_done",  32'(done), 32'(0));
    #1;
    loop_rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    repeat (60) step(1'b1, 1'b0);
    repeat (D + 2) step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
